uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter that acts as a responder on the CPU data bus (word `addr`, `re`, byte-lane `we`, `mem_ready` handshake). It sits beside the RAM behind an external address decoder. CPU stores are queued in a small TX FIFO and serialised as 8N1 frames on `txd`, so test programs can print characters without a simulator-only hook. Status and divisor registers are readable over the same bus.

---
 rtl/uart_tx_mmio.sv | 197 +++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO, a bus responder beside RAM.
// Define UART_TX_BLOCKING_EN to stall DATA writes to a full FIFO instead of dropping them.
module uart_tx_mmio #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [29:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        mem_ready,
  output logic        txd
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  localparam logic [1:0] AddrData   = 2'd0;
  localparam logic [1:0] AddrStatus = 2'd1;
  localparam logic [1:0] AddrDiv    = 2'd2;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Shifter state
  state_e      state_q;
  logic [15:0] timer_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic        txd_q;

  // FIFO and register state
  logic [7:0]      fifo_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     div_q, div_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            mem_ready_q, mem_ready_d;

  logic        fifo_full, fifo_empty, bit_tick, busy, pop;
  logic        req, data_push_req, can_push, accept, push, ovf_set, ovf_clr;
  logic [31:0] status_word;
  logic        unused_bits;

  assign unused_bits = ^{addr[29:2], wdata[31:16], we[3:2]};

  always_comb begin
    fifo_full  = (count_q == DepthCnt);
    fifo_empty = (count_q == '0);
    bit_tick   = (timer_q == 16'd0);
    busy       = (state_q != StIdle);
    // Popping from STOP lets the next frame start with no idle gap.
    pop        = !fifo_empty && ((state_q == StIdle) || ((state_q == StStop) && bit_tick));
    status_word = {24'd0, 4'(count_q), ovf_q, fifo_full, fifo_empty, busy};
  end

  always_comb begin
    req           = sel && (re || (we != 4'b0000)) && !mem_ready_q;
    data_push_req = req && (addr[1:0] == AddrData) && we[0];
    can_push      = !fifo_full || pop;
`ifdef UART_TX_BLOCKING_EN
    accept        = req && !(data_push_req && !can_push);
`else
    accept        = req;
`endif
    push          = accept && data_push_req && can_push;
    ovf_set       = accept && data_push_req && !can_push;
    ovf_clr       = accept && (addr[1:0] == AddrStatus) && we[0];
  end

  always_comb begin
    wptr_d      = wptr_q + PtrW'(push);
    rptr_d      = rptr_q + PtrW'(pop);
    count_d     = count_q + CntW'(push) - CntW'(pop);
    ovf_d       = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end else if (ovf_set) begin
      ovf_d = 1'b1;
    end

    div_d = div_q;
    if (accept && (addr[1:0] == AddrDiv)) begin
      if (we[0]) div_d[7:0]  = wdata[7:0];
      if (we[1]) div_d[15:8] = wdata[15:8];
    end

    rdata_d = 32'd0;
    if (accept && re) begin
      unique case (addr[1:0])
        AddrStatus: rdata_d = status_word;
        AddrDiv:    rdata_d = {16'd0, div_q};
        default:    rdata_d = 32'd0;
      endcase
    end
    mem_ready_d = accept;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      div_q       <= DEFAULT_DIV;
      rdata_q     <= 32'd0;
      mem_ready_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      div_q       <= div_d;
      rdata_q     <= rdata_d;
      mem_ready_q <= mem_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wptr_q] <= wdata[7:0];
    end
  end

  // Shifter FSM; the bit timer reloads from DIV at every state or bit transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      timer_q   <= 16'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
      txd_q     <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            state_q <= StStart;
            timer_q <= div_q;
            shift_q <= fifo_mem_q[rptr_q];
            txd_q   <= 1'b0;
          end
        end
        StStart: begin
          if (bit_tick) begin
            state_q   <= StData;
            timer_q   <= div_q;
            bit_cnt_q <= 3'd0;
            txd_q     <= shift_q[0];
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        StData: begin
          if (bit_tick) begin
            timer_q <= div_q;
            if (bit_cnt_q == 3'd7) begin
              state_q <= StStop;
              txd_q   <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              txd_q     <= shift_q[1];
            end
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        StStop: begin
          if (bit_tick) begin
            if (pop) begin
              state_q <= StStart;
              timer_q <= div_q;
              shift_q <= fifo_mem_q[rptr_q];
              txd_q   <= 1'b0;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            timer_q <= timer_q - 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rdata     = rdata_q;
  assign mem_ready = mem_ready_q;
  assign txd       = txd_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Randomised bench for uart_tx_mmio: a byte-queue model predicts STATUS and the serial
// waveform, and a line monitor checks every frame level-by-level against it.
module tb_uart_tx_mmio;

  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic [3:0]  we;
  logic        re;
  logic [31:0] rdata;
  logic        mem_ready;
  logic        txd;

  uart_tx_mmio #(
    .FIFO_DEPTH (Depth),
    .DEFAULT_DIV(16'd433)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sel      (sel),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .re       (re),
    .rdata    (rdata),
    .mem_ready(mem_ready),
    .txd      (txd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
  endtask

  // Reference model: bytes accepted but not yet on the line, divisor, sticky overflow.
  logic [7:0] exp_q[$];
  int         m_div = 433;
  bit         m_ovf = 1'b0;

  // Line monitor state
  bit         mon_in_frame = 1'b0;
  int         mon_nsamp, mon_total, mon_div, mon_bad;
  logic [7:0] mon_byte;
  int         mon_spurious = 0;

  function automatic logic exp_level(input logic [7:0] b, input int k, input int div);
    int idx;
    idx = k / (div + 1);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  always begin
    @(posedge clk);
    #1;
    if (mon_in_frame && (mon_nsamp == mon_total)) begin
      check_eq("frame_bits", mon_bad, 0);
      mon_in_frame = 1'b0;
      if (exp_q.size() != 0) check_eq("no_gap", {31'd0, txd}, 0);
    end
    if (mon_in_frame) begin
      if (txd !== exp_level(mon_byte, mon_nsamp, mon_div)) mon_bad++;
      mon_nsamp++;
    end else if (txd !== 1'b1) begin
      if (exp_q.size() == 0) begin
        mon_spurious++;
      end else begin
        mon_byte     = exp_q.pop_front();
        mon_div      = m_div;
        mon_total    = 10 * (m_div + 1);
        mon_nsamp    = 1;
        mon_bad      = 0;
        mon_in_frame = 1'b1;
      end
    end
  end

  // Snapshot of the model taken when a request is driven (it is sampled at the next edge).
  int snap_cnt;
  bit snap_busy;
  bit snap_ovf;
  int snap_div;

  task automatic bus(input logic s, input logic [1:0] a, input logic [31:0] d,
                     input logic [3:0] w, input logic r, input int budget,
                     output logic [31:0] rd, output int lat, output bit done);
    @(negedge clk);
    if (mem_ready) @(negedge clk);
    snap_cnt  = exp_q.size();
    snap_busy = mon_in_frame;
    snap_ovf  = m_ovf;
    snap_div  = m_div;
    sel = s; addr = {28'd0, a}; wdata = d; we = w; re = r;
    lat = 0; done = 1'b0; rd = '0;
    while (!done && (lat < budget)) begin
      @(posedge clk);
      #2;
      lat++;
      if (mem_ready) begin
        done = 1'b1;
        rd   = rdata;
      end
    end
    sel = 1'b0; we = 4'b0000; re = 1'b0;
  endtask

  task automatic rd_reg(input string tag, input logic [1:0] a);
    logic [31:0] rd, exp;
    int lat;
    bit done;
    bus(1'b1, a, 32'd0, 4'b0000, 1'b1, 50, rd, lat, done);
    case (a)
      2'd1:    exp = {24'd0, 4'(snap_cnt), snap_ovf, snap_cnt == Depth, snap_cnt == 0, snap_busy};
      2'd2:    exp = 32'(snap_div);
      default: exp = 32'd0;
    endcase
    check_eq({tag, "_lat"}, lat, 1);
    check_eq(tag, rd, exp);
  endtask

  task automatic wr_div(input logic [31:0] v, input logic [3:0] w);
    logic [31:0] rd;
    int lat;
    bit done;
    bus(1'b1, 2'd2, v, w, 1'b0, 50, rd, lat, done);
    check_eq("div_wr_lat", lat, 1);
    if (w[0]) m_div = (m_div & 32'hFF00) | int'(v[7:0]);
    if (w[1]) m_div = (m_div & 32'h00FF) | (int'(v[15:8]) << 8);
  endtask

  task automatic wr_data(input logic [7:0] b);
    logic [31:0] rd;
    int lat;
    bit done, full, idle;
    bus(1'b1, 2'd0, {24'hA5A5A5, b}, 4'b0001, 1'b0, 3000, rd, lat, done);
    full = (snap_cnt >= Depth);
    idle = (snap_cnt == 0) && !snap_busy;
`ifdef UART_TX_BLOCKING_EN
    if (full) begin
      check_eq("stall_lat", {31'd0, (lat > 3) && done}, 1);
      check_eq("stall_txd", {31'd0, txd}, 0);
    end else begin
      check_eq("data_lat", lat, 1);
    end
    exp_q.push_back(b);
`else
    check_eq("data_lat", lat, 1);
    if (full) m_ovf = 1'b1;
    else exp_q.push_back(b);
`endif
    if (idle) begin
      @(posedge clk);
      #3;
      check_eq("start_lat", {31'd0, txd}, 0);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((mon_in_frame || (exp_q.size() != 0)) && (n < 20000)) begin
      @(posedge clk);
      #3;
      n++;
    end
    check_eq("drain", exp_q.size() + int'(mon_in_frame), 0);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    int lat;
    bit done;
    int low_seen;

    reset = 1'b1; sel = 1'b0; addr = '0; wdata = '0; we = '0; re = 1'b0;
    low_seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (txd !== 1'b1) low_seen++;
    end
    @(negedge clk);
    reset = 1'b0;
    check_eq("rst_txd_low", low_seen, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_ready", {31'd0, mem_ready}, 0);

    rd_reg("status_rst", 2'd1);
    rd_reg("div_rst", 2'd2);
    @(posedge clk);
    #2;
    check_eq("rdata_clear", rdata, 0);
    check_eq("ready_pulse", {31'd0, mem_ready}, 0);

    // Single 0x55 frame at DIV=3
    wr_div(32'd3, 4'b0011);
    wr_data(8'h55);
    repeat (5) @(posedge clk);
    rd_reg("status_busy", 2'd1);
    wait_idle();
    rd_reg("status_done", 2'd1);

    // Back-to-back frames at DIV=1
    wr_div(32'd1, 4'b0011);
    wr_data(8'h41);
    wr_data(8'h42);
    wr_data(8'h43);
    rd_reg("status_cnt2", 2'd1);
    wait_idle();

    // Fill beyond capacity while the shifter is busy
    wr_div(32'd7, 4'b0011);
    for (int i = 0; i < 6; i++) wr_data(8'h60 + 8'(i));
    rd_reg("status_fill", 2'd1);
    bus(1'b1, 2'd1, 32'd1, 4'b0001, 1'b0, 50, rd, lat, done);
    check_eq("ovf_clr_lat", lat, 1);
    m_ovf = 1'b0;
    rd_reg("status_ovf_clr", 2'd1);
    wait_idle();

    // Deselected request, partial-lane DIV write, inert addresses
    bus(1'b0, 2'd1, 32'd0, 4'b0000, 1'b1, 6, rd, lat, done);
    check_eq("sel0_ignored", {31'd0, done}, 0);
    wr_div(32'h0000_ABCD, 4'b0010);
    rd_reg("div_lane1", 2'd2);
    bus(1'b1, 2'd3, 32'hFFFF_FFFF, 4'b1111, 1'b0, 50, rd, lat, done);
    check_eq("addr3_wr_lat", lat, 1);
    rd_reg("addr3_rd", 2'd3);
    rd_reg("data_rd", 2'd0);
    bus(1'b1, 2'd0, 32'h0000_7700, 4'b0010, 1'b0, 50, rd, lat, done);
    check_eq("data_we1_lat", lat, 1);
    rd_reg("div_after", 2'd2);
    rd_reg("status_nopush", 2'd1);

    // Randomised bursts, never more than Depth bytes per burst
    for (int r = 0; r < 8; r++) begin
      int nb;
      wr_div(32'($urandom_range(0, 3)), 4'b0011);
      nb = int'($urandom_range(1, Depth));
      for (int k = 0; k < nb; k++) begin
        wr_data(8'($urandom));
        repeat ($urandom_range(0, 5)) @(posedge clk);
        if ($urandom_range(0, 1) == 1) rd_reg("status_rand", 2'd1);
      end
      wait_idle();
    end
    rd_reg("status_rand_end", 2'd1);

    // Reset in the middle of a data bit
    wr_div(32'd3, 4'b0011);
    wr_data(8'hC3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    mon_in_frame = 1'b0;
    m_div = 433;
    m_ovf = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_mid_txd", {31'd0, txd}, 1);
    @(negedge clk);
    reset = 1'b0;
    repeat (60) @(posedge clk);
    rd_reg("status_after_rst", 2'd1);
    rd_reg("div_after_rst", 2'd2);

    check_eq("spurious_frames", mon_spurious, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
